imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory: the pipeline only reads it by PC, this block fills it.
//  Accepts a byte stream (count header + big-endian words) over a valid/ready handshake.
//  Writes each assembled 32-bit word to the instruction memory at consecutive word-aligned addresses.
//  Holds the pipeline (cpu_hold) for the whole load, then releases it with a one-cycle done pulse.
// PARAMETERS
//  ADDR_W     8   word-address width; capacity = 2**ADDR_W words
//  BASE_ADDR  0   byte address of the first written word (must be multiple of 4)
// PORTS
//  clk       in   1   clock, all state changes on posedge
//  rst       in   1   reset, synchronous, active-high
//  start     in   1   one-cycle request to begin a load; ignored unless state==IDLE
//  in_data   in   8   stream byte
//  in_valid  in   1   in_data valid
//  in_ready  out  1   loader accepts a byte this cycle (transfer = in_valid & in_ready)
//  im_we     out  1   instruction-memory write enable, one cycle per word
//  im_addr   out  32  byte address of the write (word aligned)
//  im_wdata  out  32  word to write
//  cpu_hold  out  1   stall PC/pipeline while high
//  busy      out  1   state != IDLE
//  done      out  1   one-cycle pulse: load completed
//  err       out  1   sticky: header count exceeds capacity
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, im_we, cpu_hold, busy, done, err = 0; im_addr=BASE_ADDR; im_wdata=0.
//  Stream format: CNT_HI, CNT_LO (N words, 16-bit big-endian), then 4*N bytes, MSB of each word first.
//  States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
//   IDLE : start -> HDR0; err cleared, im_addr<=BASE_ADDR, byte count cleared.
//   HDR0 : in_ready=1; on transfer latch cnt[15:8] -> HDR1.
//   HDR1 : in_ready=1; on transfer latch cnt[7:0]; N==0 -> DONE; N>2**ADDR_W -> ERR; else DATA.
//   DATA : in_ready=1; each transfer shifts byte into word (w<={w[23:0],b}); 4th byte -> WRITE.
//   WRITE: in_ready=0, im_we=1 for exactly one cycle with im_wdata=assembled word, im_addr=current;
//          next cycle im_addr+=4, remaining-=1; remaining reaches 0 -> DONE else DATA.
//   DONE : done=1 one cycle, -> IDLE.
//   ERR  : err=1, in_ready=0, no writes; stays until rst or start (start -> HDR0, err cleared).
//  cpu_hold = 1 in HDR0..DONE and ERR; 0 only in IDLE (asserted the cycle after start is sampled).
//  Latency: im_we asserted the cycle after the 4th byte of a word transfers.
//  Peak rate: 1 word / 5 cycles; in_valid gaps simply stall the current state, no timeout.
//  in_valid while in_ready=0: byte not consumed; source must hold it (standard valid/ready).
//  N == 2**ADDR_W accepted; last word at BASE_ADDR+4*(N-1); address never wraps.
//  start while busy: ignored. rst mid-load: immediate return to reset values, partial word
//  discarded, words already written are not undone.
//  im_addr upper bits above ADDR_W+2 are BASE_ADDR bits; arithmetic is 32-bit unsigned.
// STRUCTURE
//  Shared package: state encoding localparams, header width (16), byte-in-word counter width (2).
//  One sub-module: byte_packer (4-byte shift register + 2-bit count, outputs word and full flag).
//  FSM, address counter, remaining-word counter stay in imem_loader.
// TESTING
//  1 N=2, bytes 00 02 12 34 56 78 9A BC DE F0 -> im_we twice: (0x0,0x12345678),(0x4,0x9ABCDEF0); done 1 cycle.
//  2 N=0 (00 00) -> no im_we, done pulse the cycle after HDR1, cpu_hold low afterwards.
//  3 ADDR_W=4, header 00 11 (17) -> err=1, in_ready=0, no writes; start clears err and reloads.
//  4 Random in_valid gaps during 3-word load -> identical writes/addresses as gap-free run.
//  5 rst asserted after 6th data byte -> all outputs at reset values next cycle; fresh load works.
//  6 start pulsed mid-load -> ignored; BASE_ADDR=0x100 -> first write at 0x100.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int HDR_W      = 16;
  localparam int BYTE_CNT_W = 2;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = 2'd3;

  // Number of words the memory can hold, as a 32-bit value so the header compare never truncates.
  function automatic logic [31:0] capacity(input int addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles big-endian bytes into 32-bit words
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        full
);

  logic [23:0]           shift;
  logic [BYTE_CNT_W-1:0] count;

  // The word is complete as soon as the fourth byte is presented, so the loader can register it
  // on the same edge that accepts that byte.
  assign word = {shift, data};
  assign full = push & (count == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift <= '0;
      count <= '0;
    end else if (push) begin
      shift <= word[23:0];
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a counted big-endian word image into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] CAPACITY = capacity(ADDR_W);

  state_t           state;
  logic [7:0]       cnt_hi;
  logic [HDR_W-1:0] remaining;
  logic [HDR_W-1:0] hdr_n;
  logic             transfer;
  logic             over_cap;
  logic             launch;
  logic             pack_full;
  logic [31:0]      pack_word;

  assign transfer = in_valid & in_ready;
  assign hdr_n    = {cnt_hi, in_data};
  assign over_cap = {16'd0, hdr_n} > CAPACITY;
  assign launch   = start && (state == ST_IDLE || state == ST_ERR);

  byte_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .push  (transfer && state == ST_DATA),
    .data  (in_data),
    .word  (pack_word),
    .full  (pack_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= BASE_ADDR;
      im_wdata  <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt_hi    <= '0;
      remaining <= '0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            state    <= ST_HDR0;
            err      <= 1'b0;
            im_addr  <= BASE_ADDR;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_HDR0: begin
          if (transfer) begin
            cnt_hi <= in_data;
            state  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (transfer) begin
            remaining <= hdr_n;
            if (hdr_n == '0) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else if (over_cap) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (pack_full) begin
            state    <= ST_WRITE;
            in_ready <= 1'b0;
            im_we    <= 1'b1;
            im_wdata <= pack_word;
          end
        end
        ST_WRITE: begin
          im_addr   <= im_addr + 32'd4;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state    <= ST_DATA;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  localparam int          ADDR_W = 4;
  localparam logic [31:0] BASE   = 32'h100;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [63:0] wr_q[$];
  int          done_cnt  = 0;
  int          done_long = 0;
  logic        done_d    = 1'b0;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we) wr_q.push_back({im_addr, im_wdata});
    if (done) done_cnt++;
    if (done && done_d) done_long++;
    done_d = done;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_q_t rand_words(input int n);
    word_q_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  function automatic byte_q_t make_stream(input logic [15:0] n, input word_q_t w);
    byte_q_t s;
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (w[i]) begin
      s.push_back(w[i][31:24]);
      s.push_back(w[i][23:16]);
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
    end
    return s;
  endfunction

  // Reference: word i of the image lands at BASE + 4*i, in stream order, nothing else is written.
  task automatic compare_writes(input string tag, input word_q_t exp);
    int n;
    check({tag, "_count"}, 64'(wr_q.size()), 64'(exp.size()));
    n = (wr_q.size() < exp.size()) ? wr_q.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 64'(wr_q[i][63:32]), 64'(BASE + 32'(i) * 32'd4));
      check({tag, "_data"}, 64'(wr_q[i][31:0]), 64'(exp[i]));
    end
    wr_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input byte_q_t s, input int gap_pct, input int start_at);
    int   idx = 0;
    int   cyc = 0;
    logic pending_we = 1'b0;
    logic v;
    while (idx < s.size() && cyc < 3000) begin
      @(negedge clk);
      if (pending_we) check("we_latency", 64'(im_we), 64'd1);
      pending_we = 1'b0;
      start = (cyc == start_at);
      v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = s[idx];
      if (v && in_ready) begin
        if (idx >= 2 && ((idx - 2) % 4) == 3) pending_we = 1'b1;
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    if (pending_we) check("we_latency", 64'(im_we), 64'd1);
    check("send_complete", 64'(idx), 64'(s.size()));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic full_load(input string tag, input word_q_t w, input int gap_pct, input int start_at);
    int d0 = done_cnt;
    pulse_start();
    check({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    send(make_stream(16'(w.size()), w), gap_pct, start_at);
    wait_idle();
    compare_writes(tag, w);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_released"}, 64'(cpu_hold), 64'd0);
  endtask

  initial begin
    word_q_t w;
    byte_q_t s;
    int      d0;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_im_we",    64'(im_we),    64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_err",      64'(err),      64'd0);
    check("rst_im_addr",  64'(im_addr),  64'(BASE));
    check("rst_im_wdata", 64'(im_wdata), 64'd0);
    rst = 1'b0;

    // Fixed two-word image
    w = '{32'h12345678, 32'h9ABCDEF0};
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    full_load("t1", w, 0, -1);
    check("t1_done_width", 64'(done_long), 64'd0);

    // Empty image
    w.delete();
    d0 = done_cnt;
    pulse_start();
    send(make_stream(16'd0, w), 0, -1);
    check("t2_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t2_done_off", 64'(done), 64'd0);
    check("t2_hold_off", 64'(cpu_hold), 64'd0);
    check("t2_busy_off", 64'(busy), 64'd0);
    #1;
    check("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    compare_writes("t2", w);

    // Header one past capacity
    pulse_start();
    send(make_stream(16'(17), w), 0, -1);
    check("t3_err", 64'(err), 64'd1);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_hold", 64'(cpu_hold), 64'd1);
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (4) @(negedge clk);
    check("t3_in_ready_held", 64'(in_ready), 64'd0);
    check("t3_err_sticky", 64'(err), 64'd1);
    in_valid = 1'b0;
    compare_writes("t3", w);
    pulse_start();
    check("t3_err_cleared", 64'(err), 64'd0);
    check("t3_restart_busy", 64'(busy), 64'd1);
    w = rand_words(16);
    send(make_stream(16'd16, w), 20, -1);
    wait_idle();
    compare_writes("t3_full", w);
    check("t3_err_after", 64'(err), 64'd0);

    // Same image with and without source gaps
    w = rand_words(3);
    full_load("t4_nogap", w, 0, -1);
    full_load("t4_gap", w, 40, -1);

    // Reset after the sixth data byte
    w = rand_words(3);
    s = make_stream(16'd3, w);
    while (s.size() > 8) void'(s.pop_back());
    d0 = done_cnt;
    pulse_start();
    send(s, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_in_ready", 64'(in_ready), 64'd0);
    check("t5_cpu_hold", 64'(cpu_hold), 64'd0);
    check("t5_busy",     64'(busy),     64'd0);
    check("t5_im_we",    64'(im_we),    64'd0);
    check("t5_im_addr",  64'(im_addr),  64'(BASE));
    check("t5_im_wdata", 64'(im_wdata), 64'd0);
    rst = 1'b0;
    #1;
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    while (w.size() > 1) void'(w.pop_back());
    compare_writes("t5_partial", w);
    w = rand_words(2);
    full_load("t5_fresh", w, 10, -1);

    // Start pulses during an active load
    w = rand_words(3);
    full_load("t6_start_mid", w, 25, 6);
    full_load("t6_start_write", w, 0, 9);

    // Random sizes and gap densities
    for (int k = 0; k < 5; k++) begin
      w = rand_words($urandom_range(16, 1));
      full_load("rand", w, $urandom_range(60), $urandom_range(40));
    end
    check("done_width", 64'(done_long), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
